movimentacao_servo: RTL and testbench

MOVIMENTACAO_SERVO -- requirements
Module: movimentacao_servo

---
 rtl/movimentacao_servo.sv | 122 ++++++++++++
 tb/tb_movimentacao_servo.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/movimentacao_servo.sv
// rtl/movimentacao_servo.sv - servo position sweep FSM (00,01,10,11,10,01,...) holding each code HOLD_CICLOS cycles
// Optional manual override compiled in with `define MOVIMENTACAO_MANUAL_EN.
module movimentacao_servo #(
  parameter int HOLD_CICLOS = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       liga,
`ifdef MOVIMENTACAO_MANUAL_EN
  input  logic       manual,
  input  logic [1:0] posicao_manual,
`endif
  output logic [1:0] posicao,
  output logic       pronto,
  output logic [1:0] db_estado
);

  localparam int CW = (HOLD_CICLOS > 2) ? $clog2(HOLD_CICLOS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_CICLOS - 1);

  typedef enum logic [1:0] {
    INICIAL = 2'b00,
    PREPARA = 2'b01,
    VARRE   = 2'b10
  } estado_t;

  estado_t       r_estado;
  logic [1:0]    r_posicao;
  logic          r_pronto;
  logic [CW-1:0] r_contador;
  logic          r_dir_sobe;

  estado_t       w_estado_prox;
  logic [1:0]    w_posicao_prox;
  logic          w_pronto_prox;
  logic [CW-1:0] w_contador_prox;
  logic          w_dir_prox;
  logic [1:0]    w_pos_passo;
  logic          w_dir_passo;
  logic          w_manual_ativo;
  logic [1:0]    w_pos_manual;

`ifdef MOVIMENTACAO_MANUAL_EN
  assign w_manual_ativo = manual;
  assign w_pos_manual   = posicao_manual;
`else
  assign w_manual_ativo = 1'b0;
  assign w_pos_manual   = 2'b00;
`endif

  // Endpoints force the reversal so no code is skipped or repeated.
  always_comb begin
    w_pos_passo = r_posicao;
    w_dir_passo = r_dir_sobe;
    if (r_posicao == 2'b11) begin
      w_pos_passo = 2'b10;
      w_dir_passo = 1'b0;
    end else if (r_posicao == 2'b00) begin
      w_pos_passo = 2'b01;
      w_dir_passo = 1'b1;
    end else if (r_dir_sobe) begin
      w_pos_passo = r_posicao + 2'b01;
    end else begin
      w_pos_passo = r_posicao - 2'b01;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado   <= INICIAL;
      r_posicao  <= 2'b00;
      r_pronto   <= 1'b0;
      r_contador <= '0;
      r_dir_sobe <= 1'b1;
    end else begin
      r_estado   <= w_estado_prox;
      r_posicao  <= w_posicao_prox;
      r_pronto   <= w_pronto_prox;
      r_contador <= w_contador_prox;
      r_dir_sobe <= w_dir_prox;
    end
  end

  always_comb begin
    w_estado_prox   = INICIAL;
    w_posicao_prox  = 2'b00;
    w_pronto_prox   = 1'b0;
    w_contador_prox = '0;
    w_dir_prox      = 1'b1;
    case (r_estado)
      INICIAL: begin
        if (liga) w_estado_prox = PREPARA;
      end
      PREPARA: begin
        if (liga) w_estado_prox = VARRE;
      end
      VARRE: begin
        if (liga) begin
          w_estado_prox  = VARRE;
          w_posicao_prox = r_posicao;
          w_dir_prox     = r_dir_sobe;
          if (w_manual_ativo) begin
            w_posicao_prox = w_pos_manual;
            w_pronto_prox  = (w_pos_manual != r_posicao);
          end else if (r_contador == CNT_MAX) begin
            w_posicao_prox = w_pos_passo;
            w_dir_prox     = w_dir_passo;
            w_pronto_prox  = 1'b1;
          end else begin
            w_contador_prox = r_contador + CW'(1);
          end
        end
      end
      default: w_estado_prox = INICIAL;
    endcase
  end

  assign posicao   = r_posicao;
  assign pronto    = r_pronto;
  assign db_estado = r_estado;

endmodule

// File: tb/tb_movimentacao_servo.sv
// tb/tb_movimentacao_servo.sv - bench for movimentacao_servo with HOLD_CICLOS=4
// Manual-override scenarios run only when MOVIMENTACAO_MANUAL_EN is defined.
module tb_movimentacao_servo;
  localparam int HOLD = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       liga  = 1'b0;
`ifdef MOVIMENTACAO_MANUAL_EN
  logic       manual = 1'b0;
  logic [1:0] posicao_manual = 2'b00;
`endif
  logic [1:0] posicao;
  logic       pronto;
  logic [1:0] db_estado;

  int total = 0;
  int bad   = 0;

  movimentacao_servo #(.HOLD_CICLOS(HOLD)) dut (
    .clock          (clock),
    .reset          (reset),
    .liga           (liga),
`ifdef MOVIMENTACAO_MANUAL_EN
    .manual         (manual),
    .posicao_manual (posicao_manual),
`endif
    .posicao        (posicao),
    .pronto         (pronto),
    .db_estado      (db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 prepare, 2 sweep; m_held counts cycles spent on the current code.
  int m_st = 0, m_pos = 0, m_pronto = 0, m_held = 0, m_delta = 1;
  bit m_on = 0;

  always @(posedge clock or negedge reset) begin : model
    bit man;
    int pm;
    man = 0;
    pm  = 0;
`ifdef MOVIMENTACAO_MANUAL_EN
    man = manual;
    pm  = posicao_manual;
`endif
    if (!reset) begin
      m_st = 0; m_pos = 0; m_pronto = 0; m_held = 0; m_delta = 1;
    end else begin
      m_pronto = 0;
      if (!liga) begin
        m_st = 0; m_pos = 0; m_held = 0; m_delta = 1;
      end else if (m_st == 0) begin
        m_st = 1;
      end else if (m_st == 1) begin
        m_st = 2; m_pos = 0; m_held = 0; m_delta = 1;
      end else if (man) begin
        m_pronto = (pm != m_pos);
        m_pos = pm;
        m_held = 0;
      end else begin
        m_held++;
        if (m_held == HOLD) begin
          m_held = 0;
          m_pronto = 1;
          if (m_pos == 3) m_delta = -1;
          if (m_pos == 0) m_delta = 1;
          m_pos = m_pos + m_delta;
        end
      end
    end
  end

  always @(posedge clock) begin
    #2;
    if (m_on && reset) begin
      chk("db_estado", db_estado, m_st);
      chk("posicao", posicao, m_pos);
      chk("pronto", pronto, m_pronto);
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  int rec_pos[1:30];
  int rec_pr[1:30];
  int rec_db[1:30];
  int pulses;

  initial begin
    repeat (3) tick();
    chk("reset_db", db_estado, 0);
    chk("reset_pos", posicao, 0);
    chk("reset_pronto", pronto, 0);
    reset = 1'b1;
    m_on  = 1'b1;
    repeat (10) tick();
    chk("idle_db", db_estado, 0);

    liga = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      rec_pos[k] = posicao;
      rec_pr[k]  = pronto;
      rec_db[k]  = db_estado;
    end
    chk("lit_prepara", rec_db[1], 1);
    chk("lit_varre", rec_db[2], 2);
    chk("lit_pos_c5", rec_pos[5], 0);
    chk("lit_pos_c6", rec_pos[6], 1);
    chk("lit_pr_c6", rec_pr[6], 1);
    chk("lit_pr_c7", rec_pr[7], 0);
    chk("lit_pos_c10", rec_pos[10], 2);
    chk("lit_pos_c14", rec_pos[14], 3);
    chk("lit_pos_c18", rec_pos[18], 2);
    chk("lit_pos_c22", rec_pos[22], 1);
    chk("lit_pos_c26", rec_pos[26], 0);
    chk("lit_pos_c30", rec_pos[30], 1);
    pulses = 0;
    for (int k = 1; k <= 30; k++) pulses += rec_pr[k];
    chk("lit_pulses", pulses, 7);

    repeat (3) tick();
    liga = 1'b0;
    tick();
    chk("drop_db", db_estado, 0);
    chk("drop_pos", posicao, 0);
    chk("drop_pronto", pronto, 0);

    liga = 1'b1;
    repeat (10) tick();
    chk("pre_rst_pos", posicao, 2);
    #1 reset = 1'b0;
    #1;
    chk("async_db", db_estado, 0);
    chk("async_pos", posicao, 0);
    chk("async_pronto", pronto, 0);
    reset = 1'b1;
    tick();
    chk("restart_db", db_estado, 1);
    repeat (5) tick();
    chk("restart_pos", posicao, 1);
    chk("restart_pr", pronto, 1);

`ifdef MOVIMENTACAO_MANUAL_EN
    manual = 1'b1;
    posicao_manual = 2'b11;
    pulses = 0;
    repeat (6) begin
      tick();
      pulses += pronto;
    end
    chk("man_pulses", pulses, 1);
    chk("man_pos", posicao, 3);
    manual = 1'b0;
    repeat (3) tick();
    chk("man_hold", posicao, 3);
    tick();
    chk("man_resume", posicao, 2);
    manual = 1'b1;
    posicao_manual = 2'b10;
    pulses = 0;
    repeat (5) begin
      tick();
      pulses += pronto;
    end
    chk("man_same_pulses", pulses, 0);
    manual = 1'b0;
    repeat (4) tick();
    chk("man_same_step", posicao, 1);
`endif

    liga = 1'b0;
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
